// File: rtl/nes_controller.sv
// NES controller port at $4016/$4017 driven from a USB HID keycode.
// Each button is held for HOLD_CYCLES after its last matching keycode.
module nes_controller #(
   parameter int                HOLD_W      = 20,
   parameter logic [HOLD_W-1:0] HOLD_CYCLES = 20'd1_000_000
) (
   input  logic        MCLK,
   input  logic        RESET,
   input  logic        CPU_EN,
   input  logic [15:0] ADDR,
   input  logic        CPU_RW_n,
   input  logic [7:0]  DIN,
   output logic [7:0]  DOUT,
   output logic        DOUT_SEL,
   input  logic [7:0]  controller_keycode,
   output logic [7:0]  buttons_debug
);

   // Button bit positions: {Right,Left,Down,Up,Start,Select,B,A}
   localparam int BTN_A      = 0;
   localparam int BTN_B      = 1;
   localparam int BTN_SELECT = 2;
   localparam int BTN_START  = 3;
   localparam int BTN_UP     = 4;
   localparam int BTN_DOWN   = 5;
   localparam int BTN_LEFT   = 6;
   localparam int BTN_RIGHT  = 7;

   logic [7:0]        match;
   logic [7:0]        clr;
   logic [7:0]        pressed;
   logic [HOLD_W-1:0] hold_cnt [8];
   logic              strobe;
   logic [7:0]        shift;
   logic              sel_4016;
   logic              sel_4017;
   logic              rd_4016;
   logic              wr_4016;
   logic              unused_din;

   assign unused_din = ^DIN[7:1];

   always_comb begin
      match = 8'h00;
      case (controller_keycode)
         8'h0E:   match[BTN_A]      = 1'b1;
         8'h0D:   match[BTN_B]      = 1'b1;
         8'h2C:   match[BTN_SELECT] = 1'b1;
         8'h28:   match[BTN_START]  = 1'b1;
         8'h1A:   match[BTN_UP]     = 1'b1;
         8'h16:   match[BTN_DOWN]   = 1'b1;
         8'h04:   match[BTN_LEFT]   = 1'b1;
         8'h07:   match[BTN_RIGHT]  = 1'b1;
         default: match = 8'h00;
      endcase
   end

   // Loading one direction kills its opposite so the pad never reports both.
   always_comb begin
      clr            = 8'h00;
      clr[BTN_UP]    = match[BTN_DOWN];
      clr[BTN_DOWN]  = match[BTN_UP];
      clr[BTN_LEFT]  = match[BTN_RIGHT];
      clr[BTN_RIGHT] = match[BTN_LEFT];
   end

   always_ff @(posedge MCLK) begin
      for (int i = 0; i < 8; i++) begin
         if (RESET)
            hold_cnt[i] <= '0;
         else if (match[i])
            hold_cnt[i] <= HOLD_CYCLES;
         else if (clr[i])
            hold_cnt[i] <= '0;
         else if (hold_cnt[i] != '0)
            hold_cnt[i] <= hold_cnt[i] - {{(HOLD_W-1){1'b0}}, 1'b1};
      end
   end

   always_comb begin
      for (int i = 0; i < 8; i++)
         pressed[i] = |hold_cnt[i];
   end

   assign buttons_debug = pressed;

   assign sel_4016 = (ADDR == 16'h4016);
   assign sel_4017 = (ADDR == 16'h4017);
   assign rd_4016  = CPU_EN &  CPU_RW_n & sel_4016;
   assign wr_4016  = CPU_EN & ~CPU_RW_n & sel_4016;

   // The strobe in effect during a 1->0 write still reloads, so the shift
   // register ends up holding the vector seen on that write's cycle.
   always_ff @(posedge MCLK) begin
      if (RESET) begin
         strobe <= 1'b0;
         shift  <= 8'hFF;
      end else begin
         if (wr_4016)
            strobe <= DIN[0];
         if (strobe)
            shift <= pressed;
         else if (rd_4016)
            shift <= {1'b1, shift[7:1]};
      end
   end

   assign DOUT_SEL = (sel_4016 | sel_4017) & CPU_RW_n;

   // Upper bits model the open-bus $40 pattern; while strobed, A is live.
   always_comb begin
      DOUT = 8'h00;
      if (DOUT_SEL) begin
         if (sel_4016)
            DOUT = {7'b0100000, (strobe ? pressed[BTN_A] : shift[0])};
         else
            DOUT = 8'h40;
      end
   end

endmodule

// File: tb/tb_nes_controller.sv
// Self-checking bench for nes_controller: hold timing, lockout, strobe and
// shift-read sequences, reset mid-sequence and unqualified bus accesses.
module tb_nes_controller;

   localparam int          HOLD_W      = 20;
   localparam logic [19:0] HOLD_CYCLES = 20'd100;

   logic        MCLK = 1'b0;
   logic        RESET;
   logic        CPU_EN;
   logic [15:0] ADDR;
   logic        CPU_RW_n;
   logic [7:0]  DIN;
   logic [7:0]  DOUT;
   logic        DOUT_SEL;
   logic [7:0]  controller_keycode;
   logic [7:0]  buttons_debug;

   int vectors     = 0;
   int miscompares = 0;
   logic [7:0] exp_q[$];

   nes_controller #(
      .HOLD_W      (HOLD_W),
      .HOLD_CYCLES (HOLD_CYCLES)
   ) dut (
      .MCLK               (MCLK),
      .RESET              (RESET),
      .CPU_EN             (CPU_EN),
      .ADDR               (ADDR),
      .CPU_RW_n           (CPU_RW_n),
      .DIN                (DIN),
      .DOUT               (DOUT),
      .DOUT_SEL           (DOUT_SEL),
      .controller_keycode (controller_keycode),
      .buttons_debug      (buttons_debug)
   );

   // ---------------- clock / reset ----------------
   always #5 MCLK = ~MCLK;

   task automatic tick;
      @(posedge MCLK);
      #1;
   endtask

   task automatic bus_idle;
      CPU_EN   = 1'b0;
      CPU_RW_n = 1'b1;
      ADDR     = 16'h0000;
      DIN      = 8'h00;
   endtask

   task automatic do_reset;
      RESET              = 1'b1;
      controller_keycode = 8'h00;
      bus_idle();
      tick();
      RESET = 1'b0;
   endtask

   // ---------------- driver tasks ----------------
   task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
      CPU_EN   = 1'b1;
      CPU_RW_n = 1'b0;
      ADDR     = a;
      DIN      = d;
      tick();
      bus_idle();
   endtask

   task automatic cpu_read(input logic [15:0] a, output logic [7:0] d);
      CPU_EN   = 1'b1;
      CPU_RW_n = 1'b1;
      ADDR     = a;
      @(negedge MCLK);
      d = DOUT;
      tick();
      bus_idle();
   endtask

   task automatic hold_key(input logic [7:0] k, input int n);
      controller_keycode = k;
      repeat (n) tick();
   endtask

   // Expected $4016 read stream for a captured vector: bit0 first, then 1s.
   task automatic push_stream(input logic [7:0] cap, input int n);
      for (int i = 0; i < n; i++) begin
         if (i < 8) exp_q.push_back({7'b0100000, cap[i]});
         else       exp_q.push_back(8'h41);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      logic [7:0] got;
      logic [7:0] exp;
      do_reset();
      vectors++;
      if (buttons_debug !== 8'h00) begin
         miscompares++;
         $display("FAIL reset_buttons got=%h exp=%h", buttons_debug, 8'h00);
      end
      vectors++;
      if (DOUT_SEL !== 1'b0 || DOUT !== 8'h00) begin
         miscompares++;
         $display("FAIL reset_idle_bus got sel=%b dout=%h exp sel=0 dout=00", DOUT_SEL, DOUT);
      end
      exp_q.push_back(8'h41);
      exp_q.push_back(8'h41);
      for (int i = 0; i < 2; i++) begin
         cpu_read(16'h4016, got);
         exp = exp_q.pop_front();
         vectors++;
         if (got !== exp) begin
            miscompares++;
            $display("FAIL reset_read%0d got=%h exp=%h", i, got, exp);
         end
      end
   endtask

   task automatic test_sequence_read;
      logic [7:0] got;
      logic [7:0] exp;
      do_reset();
      for (int r = 0; r < 2; r++) begin
         hold_key(8'h0E, 10);
         hold_key(8'h28, 10);
      end
      cpu_write(16'h4016, 8'h01);
      cpu_write(16'h4016, 8'h00);
      push_stream(8'b0000_1001, 10);
      controller_keycode = 8'h07;
      for (int i = 0; i < 10; i++) begin
         if (i == 4) controller_keycode = 8'h0D;
         cpu_read(16'h4016, got);
         exp = exp_q.pop_front();
         vectors++;
         if (got !== exp) begin
            miscompares++;
            $display("FAIL seq_read%0d got=%h exp=%h", i, got, exp);
         end
      end
   endtask

   task automatic test_hold_timeout;
      do_reset();
      hold_key(8'h1A, 1);
      controller_keycode = 8'h00;
      for (int k = 0; k < 100; k++) begin
         vectors++;
         if (buttons_debug !== 8'h10) begin
            miscompares++;
            $display("FAIL hold_cycle%0d got=%h exp=%h", k, buttons_debug, 8'h10);
         end
         tick();
      end
      vectors++;
      if (buttons_debug !== 8'h00) begin
         miscompares++;
         $display("FAIL hold_expired got=%h exp=%h", buttons_debug, 8'h00);
      end
   endtask

   task automatic test_lockout;
      do_reset();
      hold_key(8'h1A, 1);
      hold_key(8'h16, 1);
      hold_key(8'h00, 3);
      vectors++;
      if (buttons_debug !== 8'h20) begin
         miscompares++;
         $display("FAIL lock_up_down got=%h exp=%h", buttons_debug, 8'h20);
      end
      hold_key(8'h1A, 1);
      controller_keycode = 8'h00;
      vectors++;
      if (buttons_debug !== 8'h10) begin
         miscompares++;
         $display("FAIL lock_down_up got=%h exp=%h", buttons_debug, 8'h10);
      end
      do_reset();
      hold_key(8'h04, 1);
      hold_key(8'h07, 1);
      controller_keycode = 8'h00;
      vectors++;
      if (buttons_debug !== 8'h80) begin
         miscompares++;
         $display("FAIL lock_left_right got=%h exp=%h", buttons_debug, 8'h80);
      end
      hold_key(8'h04, 1);
      controller_keycode = 8'h00;
      vectors++;
      if (buttons_debug !== 8'h40) begin
         miscompares++;
         $display("FAIL lock_right_left got=%h exp=%h", buttons_debug, 8'h40);
      end
   endtask

   task automatic test_strobe_hold;
      logic [7:0] got;
      logic [7:0] exp;
      do_reset();
      hold_key(8'h1A, 1);
      hold_key(8'h04, 1);
      hold_key(8'h0D, 1);
      hold_key(8'h0E, 1);
      cpu_write(16'h4016, 8'h01);
      for (int i = 0; i < 3; i++) exp_q.push_back(8'h41);
      push_stream(8'b0101_0011, 9);
      for (int i = 0; i < 12; i++) begin
         if (i == 3) cpu_write(16'h4016, 8'h00);
         cpu_read(16'h4016, got);
         exp = exp_q.pop_front();
         vectors++;
         if (got !== exp) begin
            miscompares++;
            $display("FAIL strobe_read%0d got=%h exp=%h", i, got, exp);
         end
      end
      // Live A while strobed: the press is visible in its first held cycle.
      do_reset();
      cpu_write(16'h4016, 8'h01);
      exp_q.push_back(8'h40);
      exp_q.push_back(8'h41);
      for (int i = 0; i < 2; i++) begin
         if (i == 1) hold_key(8'h0E, 1);
         cpu_read(16'h4016, got);
         exp = exp_q.pop_front();
         vectors++;
         if (got !== exp) begin
            miscompares++;
            $display("FAIL live_a%0d got=%h exp=%h", i, got, exp);
         end
      end
      controller_keycode = 8'h00;
   endtask

   task automatic test_reset_mid_read;
      logic [7:0] got;
      logic [7:0] exp;
      do_reset();
      hold_key(8'h0E, 2);
      hold_key(8'h28, 2);
      controller_keycode = 8'h00;
      cpu_write(16'h4016, 8'h01);
      cpu_write(16'h4016, 8'h00);
      push_stream(8'b0000_1001, 3);
      for (int i = 0; i < 3; i++) begin
         cpu_read(16'h4016, got);
         exp = exp_q.pop_front();
         vectors++;
         if (got !== exp) begin
            miscompares++;
            $display("FAIL midrst_pre%0d got=%h exp=%h", i, got, exp);
         end
      end
      RESET              = 1'b1;
      controller_keycode = 8'h0E;
      CPU_EN             = 1'b1;
      CPU_RW_n           = 1'b1;
      ADDR               = 16'h4016;
      tick();
      RESET              = 1'b0;
      controller_keycode = 8'h00;
      bus_idle();
      vectors++;
      if (buttons_debug !== 8'h00) begin
         miscompares++;
         $display("FAIL midrst_buttons got=%h exp=%h", buttons_debug, 8'h00);
      end
      for (int i = 0; i < 4; i++) exp_q.push_back(8'h41);
      for (int i = 0; i < 4; i++) begin
         cpu_read(16'h4016, got);
         exp = exp_q.pop_front();
         vectors++;
         if (got !== exp) begin
            miscompares++;
            $display("FAIL midrst_post%0d got=%h exp=%h", i, got, exp);
         end
      end
   endtask

   task automatic test_unqualified;
      logic [7:0] got;
      logic [7:0] exp;
      logic [15:0] addrs [4];
      logic        rws   [4];
      logic        sels  [4];
      logic [7:0]  douts [4];
      addrs = '{16'h4016, 16'h4017, 16'h4016, 16'h4015};
      rws   = '{1'b1, 1'b1, 1'b0, 1'b1};
      sels  = '{1'b1, 1'b1, 1'b0, 1'b0};
      douts = '{8'h40, 8'h40, 8'h00, 8'h00};
      do_reset();
      hold_key(8'h0D, 1);
      hold_key(8'h2C, 1);
      controller_keycode = 8'h00;
      cpu_write(16'h4016, 8'h01);
      cpu_write(16'h4016, 8'h00);
      for (int i = 0; i < 4; i++) begin
         CPU_EN   = 1'b0;
         CPU_RW_n = rws[i];
         ADDR     = addrs[i];
         @(negedge MCLK);
         vectors++;
         if (DOUT_SEL !== sels[i] || DOUT !== douts[i]) begin
            miscompares++;
            $display("FAIL unqual%0d got sel=%b dout=%h exp sel=%b dout=%h",
                     i, DOUT_SEL, DOUT, sels[i], douts[i]);
         end
         tick();
      end
      bus_idle();
      exp_q.push_back(8'h40);
      cpu_read(16'h4017, got);
      exp = exp_q.pop_front();
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL read_4017 got=%h exp=%h", got, exp);
      end
      cpu_write(16'h4017, 8'h01);
      push_stream(8'b0000_0110, 9);
      for (int i = 0; i < 9; i++) begin
         cpu_read(16'h4016, got);
         exp = exp_q.pop_front();
         vectors++;
         if (got !== exp) begin
            miscompares++;
            $display("FAIL unqual_stream%0d got=%h exp=%h", i, got, exp);
         end
      end
   endtask

   // ---------------- main sequence / report ----------------
   initial begin
      RESET              = 1'b1;
      controller_keycode = 8'h00;
      bus_idle();
      test_reset();
      test_sequence_read();
      test_hold_timeout();
      test_lockout();
      test_strobe_hold();
      test_reset_mid_read();
      test_unqualified();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout vectors=%0d", vectors);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/nes_controller.md
NES_CONTROLLER -- requirements
Module: nes_controller

Interface
- REQ-001: Parameter HOLD_W, default 20, sets the width of each button hold counter.
- REQ-002: Parameter HOLD_CYCLES, default 20'd1_000_000 (about 46 ms at 21.5 MHz), is the hold time in MCLK cycles after the last matching keycode.
- REQ-003: MCLK  input  1  single system clock; all state changes on its rising edge.
- REQ-004: RESET  input  1  synchronous, active-high reset.
- REQ-005: CPU_EN  input  1  one-MCLK pulse marking the cycle in which the CPU bus access is valid.
- REQ-006: ADDR  input  16  CPU address bus.
- REQ-007: CPU_RW_n  input  1  1 = read, 0 = write.
- REQ-008: DIN  input  8  CPU write data.
- REQ-009: DOUT  output  8  read data for $4016/$4017.
- REQ-010: DOUT_SEL  output  1  high when ADDR is $4016 or $4017 and CPU_RW_n=1; the bus mux uses it.
- REQ-011: controller_keycode  input  8  USB HID keycode from the SoC; 8'h00 means no key.
- REQ-012: buttons_debug  output  8  current held-button vector {Right,Left,Down,Up,Start,Select,B,A}.

Function
- REQ-013: Keycode decode SHALL be:
  - 8'h0E -> A
  - 8'h0D -> B
  - 8'h2C -> Select
  - 8'h28 -> Start
  - 8'h1A -> Up
  - 8'h16 -> Down
  - 8'h04 -> Left
  - 8'h07 -> Right
  - any other code matches no button.
- REQ-014: Each button SHALL have a HOLD_W-bit counter.
  - A matching keycode reloads it to HOLD_CYCLES every cycle.
  - Otherwise a nonzero counter decrements by 1 per cycle and saturates at 0.
- REQ-015: A button SHALL be pressed iff its counter is nonzero; buttons_debug reflects the counters registered in the same cycle.
- REQ-016: Opposite-direction lockout:
  - Loading Up clears Down's counter to 0 in the same cycle, and vice versa.
  - Loading Left clears Right's counter to 0 in the same cycle, and vice versa.
- REQ-017: Strobe register: a write (CPU_EN=1, CPU_RW_n=0, ADDR=16'h4016) SHALL store strobe <= DIN[0].
- REQ-018: While strobe=1, the 8-bit shift register SHALL reload from the button vector every cycle, with bit0 = A.
- REQ-019: A strobe 1->0 write SHALL leave the shift register holding the vector captured on that write's cycle.
- REQ-020: DOUT for $4016 SHALL be {7'b0100000, shift[0]} combinationally, including the open-bus $40 pattern.
- REQ-021: On a qualified $4016 read (CPU_EN=1, CPU_RW_n=1, ADDR=16'h4016) with strobe=0, the shift register SHALL shift right one bit at the clock edge ending the cycle, filling bit7 with 1.
- REQ-022: Bit order delivered across reads SHALL be A, B, Select, Start, Up, Down, Left, Right; every read after the eighth returns 1.
- REQ-023: A read with strobe=1 SHALL return the live A state and SHALL NOT shift.
- REQ-024: DOUT for $4017 SHALL be 8'h40 constant (no second controller); $4017 reads and writes change no state.
- REQ-025: Any access with CPU_EN=0 SHALL have no side effect; DOUT and DOUT_SEL stay combinational from ADDR and CPU_RW_n.
- REQ-026: A keycode change while strobe=0 SHALL NOT alter the shift register; it only updates the counters.
- REQ-027: DOUT SHALL be 8'h00 when DOUT_SEL=0.

Reset
- REQ-028: RESET=1 SHALL clear all hold counters to 0, strobe to 0, and the shift register to 8'hFF.
- REQ-029: After reset, buttons_debug = 8'h00 and a $4016 read returns 8'h41.
- REQ-030: RESET SHALL take priority over any simultaneous bus access or keycode, including reset asserted in the middle of a read sequence.
- REQ-031: Operation resumes on the first cycle after RESET deasserts.

Verification
- REQ-032: Hold K (8'h0E) and Enter (8'h28) alternately, 10 cycles each; write $4016=1 then $4016=0; do 8 reads -> 1,0,0,1,0,0,0,0; the 9th and 10th reads -> 1 (DOUT 8'h41).
- REQ-033: Drive keycode 8'h1A for 1 cycle then 8'h00, with HOLD_CYCLES=100 -> Up set for exactly 100 cycles after the load cycle, then buttons_debug=8'h00.
- REQ-034: Load Up, then Down on the next cycle -> buttons_debug bit4=0 and bit5=1; the Up counter reads 0.
- REQ-035: With strobe=1 and A held, do 3 reads -> each returns 8'h41, no shift; after the 0 write, 8 reads return the captured vector.
- REQ-036: Mid-sequence (after 3 reads), assert RESET for 1 cycle -> the next read returns 8'h41; buttons_debug=8'h00; strobe=0.
- REQ-037: Read $4016 and $4017 with CPU_EN=0 -> DOUT_SEL=1 with data per REQ-020/REQ-024, and no shift occurs (the subsequent qualified read returns the expected first bit).
